alu: RTL and testbench

ALU -- requirements
Module: ALU

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_flags.sv | 28 ++
 rtl/alu.sv | 47 ++++
 tb/tb_alu.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and flag indexing for the registered adder ALU.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned NUM_FLAGS     = 5;

  // Bit positions of each status flag within the packed flag vector.
  typedef enum logic [2:0] {
    SIGN     = 3'd0,
    ZERO     = 3'd1,
    CARRY    = 3'd2,
    PARITY   = 3'd3,
    OVERFLOW = 3'd4
  } flag_idx_e;

endpackage

// File: rtl/alu_flags.sv
// Combinational adder: produces the modular sum and the five status flags.
module alu_flags
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic [WIDTH-1:0]     sum,
  output logic [NUM_FLAGS-1:0] flags
);

  logic [WIDTH:0] full;

  // Single unsigned WIDTH+1-bit addition; every flag derives from it and the operand MSBs.
  always_comb begin
    full            = {1'b0, x} + {1'b0, y};
    sum             = full[WIDTH-1:0];
    flags           = '0;
    flags[SIGN]     = full[WIDTH-1];
    flags[ZERO]     = (full[WIDTH-1:0] == '0);
    flags[CARRY]    = full[WIDTH];
    flags[PARITY]   = ~^full[WIDTH-1:0];
    flags[OVERFLOW] = (x[WIDTH-1] & y[WIDTH-1] & ~full[WIDTH-1]) |
                      (~x[WIDTH-1] & ~y[WIDTH-1] & full[WIDTH-1]);
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle-latency sum and flags with asynchronous active-low reset.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             sign,
  output logic             zero,
  output logic             carry,
  output logic             parity,
  output logic             overflow
);

  logic [WIDTH-1:0]     sum;
  logic [NUM_FLAGS-1:0] flags;
  logic [NUM_FLAGS-1:0] flag_q;

  alu_flags #(.WIDTH(WIDTH)) u_flags (
    .x     (x),
    .y     (y),
    .sum   (sum),
    .flags (flags)
  );

  // Capture the sum and all flags together each edge; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z      <= '0;
      flag_q <= '0;
    end else begin
      z      <= sum;
      flag_q <= flags;
    end
  end

  assign sign     = flag_q[SIGN];
  assign zero     = flag_q[ZERO];
  assign carry    = flag_q[CARRY];
  assign parity   = flag_q[PARITY];
  assign overflow = flag_q[OVERFLOW];

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, reset behaviour and random back-to-back traffic.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] z;
  logic        sign;
  logic        zero;
  logic        carry;
  logic        parity;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  alu #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .y        (y),
    .z        (z),
    .sign     (sign),
    .zero     (zero),
    .carry    (carry),
    .parity   (parity),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: arithmetic on plain integers, flags from their mathematical definitions.
  task automatic expect_sum(input string tag, input logic [15:0] ax, input logic [15:0] ay);
    int unsigned total;
    int unsigned s16;
    int sx;
    int sy;
    int ssum;
    total = ax + ay;
    s16   = total % 65536;
    sx    = $signed(ax);
    sy    = $signed(ay);
    ssum  = sx + sy;
    check({tag, ":z"},        {16'd0, z},       s16);
    check({tag, ":sign"},     {31'd0, sign},    (s16 >= 32768) ? 1 : 0);
    check({tag, ":zero"},     {31'd0, zero},    (s16 == 0) ? 1 : 0);
    check({tag, ":carry"},    {31'd0, carry},   (total >= 65536) ? 1 : 0);
    check({tag, ":parity"},   {31'd0, parity},  ($countones(s16) % 2 == 0) ? 1 : 0);
    check({tag, ":overflow"}, {31'd0, overflow}, (ssum > 32767 || ssum < -32768) ? 1 : 0);
  endtask

  task automatic expect_reset(input string tag);
    check({tag, ":z"},        {16'd0, z},        0);
    check({tag, ":sign"},     {31'd0, sign},     0);
    check({tag, ":zero"},     {31'd0, zero},     0);
    check({tag, ":carry"},    {31'd0, carry},    0);
    check({tag, ":parity"},   {31'd0, parity},   0);
    check({tag, ":overflow"}, {31'd0, overflow}, 0);
  endtask

  task automatic apply(input string tag, input logic [15:0] ax, input logic [15:0] ay);
    @(negedge clk);
    x = ax;
    y = ay;
    @(posedge clk);
    #1;
    expect_sum(tag, ax, ay);
  endtask

  logic [15:0] dx [4];
  logic [15:0] dy [4];
  logic [15:0] px;
  logic [15:0] py;

  initial begin
    dx[0] = 16'h8fff; dy[0] = 16'h8000;
    dx[1] = 16'hfffe; dy[1] = 16'h0002;
    dx[2] = 16'haaaa; dy[2] = 16'h5555;
    dx[3] = 16'h7fff; dy[3] = 16'h0001;

    rst_n = 1'b0;
    x     = 16'h1234;
    y     = 16'h4321;
    #1;
    expect_reset("reset_initial");
    repeat (3) @(posedge clk);
    #1;
    expect_reset("reset_held_over_edges");

    // Release between edges; the first edge loads the current operands.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_sum("first_after_release", 16'h1234, 16'h4321);

    // Literal vectors plus the mathematical model.
    apply("vec_8fff_8000", dx[0], dy[0]);
    check("vec0_literal_z", {16'd0, z}, 32'h0fff);
    check("vec0_literal_flags", {27'd0, sign, zero, carry, parity, overflow}, 32'b00111);
    apply("vec_fffe_0002", dx[1], dy[1]);
    check("vec1_literal_flags", {27'd0, sign, zero, carry, parity, overflow}, 32'b01110);
    apply("vec_aaaa_5555", dx[2], dy[2]);
    check("vec2_literal_flags", {27'd0, sign, zero, carry, parity, overflow}, 32'b10010);
    apply("vec_7fff_0001", dx[3], dy[3]);
    check("vec3_literal_flags", {27'd0, sign, zero, carry, parity, overflow}, 32'b10001);
    apply("zero_plus_zero", 16'h0000, 16'h0000);
    apply("ffff_plus_ffff", 16'hffff, 16'hffff);
    apply("8000_plus_8000", 16'h8000, 16'h8000);

    // Outputs hold between edges even when inputs move.
    apply("hold_setup", 16'h0102, 16'h0304);
    x = 16'hffff;
    y = 16'h0001;
    #2;
    expect_sum("hold_mid_cycle", 16'h0102, 16'h0304);

    // Mid-cycle asynchronous reset after a nonzero result.
    apply("pre_async_reset", 16'h1111, 16'h2222);
    #2;
    rst_n = 1'b0;
    #1;
    expect_reset("async_reset_mid_cycle");
    x = 16'h7000;
    y = 16'h1000;
    @(posedge clk);
    #1;
    expect_reset("async_reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expect_reset("released_before_edge");
    @(posedge clk);
    #1;
    expect_sum("after_async_release", 16'h7000, 16'h1000);

    // Back-to-back random pairs, one per cycle; each result is checked one edge later.
    @(negedge clk);
    px = 16'($urandom);
    py = 16'($urandom);
    x  = px;
    y  = py;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      expect_sum($sformatf("b2b_%0d", i), px, py);
      @(negedge clk);
      case (i % 6)
        0:       begin px = 16'($urandom); py = 16'(-int'(px)); end
        1:       begin px = 16'h7fff; py = 16'($urandom_range(0, 3)); end
        default: begin px = 16'($urandom); py = 16'($urandom); end
      endcase
      x = px;
      y = py;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
